// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier issue unit: FSM states,
// default sizing constants and the queued operand-pair layout.
package mul_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } mul_state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] multiplicand;
        logic [DEF_WIDTH-1:0] multiplier;
    } op_pair_t;

endpackage

// File: rtl/mul_operand_fifo.sv
// Synchronous FIFO holding queued operand pairs; write-to-read latency 1 cycle.
// Backpressure: push ignored when full, pop ignored when empty; no bypass.
module mul_operand_fifo
    import mul_pkg::*;
#(
    parameter int DATA_W = 2 * DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_dat,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/mul_issue_unit.sv
// Queues operand pairs and issues them one at a time to a sequential multiplier;
// zero operands bypass the multiplier, results held until res_ready, in_ready = !full.
module mul_issue_unit
    import mul_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_multiplicand,
    input  logic [WIDTH-1:0]   in_multiplier,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplier,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
    output logic               res_error,
    output logic               err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [WIDTH-1:0] multiplicand;
        logic [WIDTH-1:0] multiplier;
    } pair_t;

    mul_state_t       state;
    mul_state_t       state_nxt;
    pair_t            push_pair;
    pair_t            head_pair;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CW-1:0]    wait_cnt;
    logic             op_zero;
    logic             wait_expired;

    assign push_pair        = {in_multiplicand, in_multiplier};
    assign in_ready         = !fifo_full;
    assign fifo_pop         = (state == ST_IDLE) && !fifo_empty;
    assign op_zero          = (op_a == '0) || (op_b == '0);
    assign wait_expired     = (wait_cnt == CNT_LAST);
    assign mul_multiplicand = op_a;
    assign mul_multiplier   = op_b;

    mul_operand_fifo #(
        .DATA_W ($bits(pair_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_dat (push_pair),
        .pop      (fifo_pop),
        .pop_dat  (head_pair),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (op_zero) begin
                    state_nxt = ST_HOLD;
                end else begin
                    mul_start = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            // Completion takes priority over an expiring counter in the same cycle.
            ST_WAIT:  if (mul_done || wait_expired) state_nxt = ST_HOLD;
            ST_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            wait_cnt    <= '0;
            res_product <= '0;
            res_error   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_a <= head_pair.multiplicand;
                        op_b <= head_pair.multiplier;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    if (op_zero) begin
                        res_product <= '0;
                        res_error   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        res_product <= mul_product;
                        res_error   <= 1'b0;
                    end else if (wait_expired) begin
                        res_product <= '0;
                        res_error   <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed bench for mul_issue_unit with a delay-programmable multiplier model.
// Cycle indices count negedges after the push edge (push observed at n = 0).
module tb_mul_issue_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_multiplicand;
    logic [15:0] in_multiplier;
    logic        mul_start;
    logic [15:0] mul_multiplicand;
    logic [15:0] mul_multiplier;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_product;
    logic        res_error;
    logic        err_timeout;

    logic        model_done;
    logic [31:0] model_product;
    logic        spur_done;
    logic [31:0] spur_product;
    logic        model_en;
    int          model_delay;

    int checks;
    int passed;

    assign mul_done    = model_done | spur_done;
    assign mul_product = spur_done ? spur_product : model_product;

    mul_issue_unit #(.WIDTH(16), .DEPTH(4), .TIMEOUT(40)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_done         (mul_done),
        .mul_product      (mul_product),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_product      (res_product),
        .res_error        (res_error),
        .err_timeout      (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier model: done asserted model_delay cycles after the start cycle.
    initial begin
        logic [15:0] ma;
        logic [15:0] mb;
        model_done    = 1'b0;
        model_product = '0;
        forever begin
            @(negedge clk);
            if (mul_start && model_en) begin
                ma = mul_multiplicand;
                mb = mul_multiplier;
                repeat (model_delay) @(negedge clk);
                model_done    = 1'b1;
                model_product = {16'd0, ma} * {16'd0, mb};
                @(negedge clk);
                model_done    = 1'b0;
                model_product = '0;
            end
        end
    end

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        in_valid        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        @(negedge clk);
        in_valid        = 1'b0;
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input int budget,
                           output int s_at, output int s_cnt, output int v_at, output bit stable);
        int n;
        s_at   = -1;
        s_cnt  = 0;
        v_at   = -1;
        stable = 1'b1;
        push_pair(a, b);
        n = 1;
        while (n <= budget && v_at < 0) begin
            if (mul_start) begin
                s_cnt++;
                if (s_at < 0) s_at = n;
            end
            if (s_at >= 0 && (mul_multiplicand !== a || mul_multiplier !== b)) stable = 1'b0;
            if (res_valid) v_at = n;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid); else passed++;
        checks++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start got %b want 0", mul_start); else passed++;
        checks++; if (res_product !== 32'd0 || res_error !== 1'b0)
            $display("FAIL reset_result got %0d/%b want 0/0", res_product, res_error); else passed++;
        checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err_timeout got %b want 0", err_timeout); else passed++;
        checks++; if (mul_multiplicand !== 16'd0 || mul_multiplier !== 16'd0)
            $display("FAIL reset_operands got %0d,%0d want 0,0", mul_multiplicand, mul_multiplier); else passed++;
    endtask

    task automatic test_multiply();
        int s_at, s_cnt, v_at;
        bit stable;
        model_en    = 1'b1;
        model_delay = 17;
        run_one(16'd3, 16'd5, 60, s_at, s_cnt, v_at, stable);
        checks++; if (s_at !== 2) $display("FAIL mul_start_cycle got %0d want 2", s_at); else passed++;
        checks++; if (s_cnt !== 1) $display("FAIL mul_start_pulses got %0d want 1", s_cnt); else passed++;
        checks++; if (stable !== 1'b1) $display("FAIL mul_operands_stable got %b want 1", stable); else passed++;
        checks++; if (v_at !== 20) $display("FAIL mul_valid_cycle got %0d want 20", v_at); else passed++;
        checks++; if (res_product !== 32'd15 || res_error !== 1'b0)
            $display("FAIL mul_result got %0d/%b want 15/0", res_product, res_error); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_product !== 32'd15)
            $display("FAIL mul_hold got %b/%0d want 1/15", res_valid, res_product); else passed++;
        release_result();
        checks++; if (res_valid !== 1'b0) $display("FAIL mul_release got %b want 0", res_valid); else passed++;
    endtask

    task automatic test_zero_bypass();
        int s_at, s_cnt, v_at;
        bit stable;
        run_one(16'd0, 16'd1234, 20, s_at, s_cnt, v_at, stable);
        checks++; if (s_cnt !== 0) $display("FAIL zero_a_start got %0d want 0", s_cnt); else passed++;
        checks++; if (v_at !== 3) $display("FAIL zero_a_valid_cycle got %0d want 3", v_at); else passed++;
        checks++; if (res_product !== 32'd0 || res_error !== 1'b0)
            $display("FAIL zero_a_result got %0d/%b want 0/0", res_product, res_error); else passed++;
        release_result();
        run_one(16'd77, 16'd0, 20, s_at, s_cnt, v_at, stable);
        checks++; if (s_cnt !== 0 || v_at !== 3)
            $display("FAIL zero_b got starts %0d valid %0d want 0 3", s_cnt, v_at); else passed++;
        release_result();
    endtask

    task automatic test_done_at_timeout();
        int s_at, s_cnt, v_at;
        bit stable;
        model_en    = 1'b1;
        model_delay = 40;
        run_one(16'd100, 16'd200, 80, s_at, s_cnt, v_at, stable);
        checks++; if (v_at !== 43) $display("FAIL edge_valid_cycle got %0d want 43", v_at); else passed++;
        checks++; if (res_product !== 32'd20000 || res_error !== 1'b0)
            $display("FAIL edge_result got %0d/%b want 20000/0", res_product, res_error); else passed++;
        checks++; if (err_timeout !== 1'b0) $display("FAIL edge_err_timeout got %b want 0", err_timeout); else passed++;
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa [6];
        logic [15:0] pb [6];
        logic [31:0] exp_p [6];
        int acc, got, idx;
        logic rdy;
        pa    = '{16'd1, 16'd3, 16'd0, 16'd6, 16'd8, 16'd9};
        pb    = '{16'd2, 16'd4, 16'd5, 16'd7, 16'd0, 16'd10};
        exp_p = '{32'd2, 32'd12, 32'd0, 32'd42, 32'd0, 32'd90};
        model_en    = 1'b1;
        model_delay = 2;
        res_ready   = 1'b0;
        acc = 0;
        for (int c = 0; c < 15; c++) begin
            idx             = (acc < 6) ? acc : 5;
            in_valid        = (acc < 6);
            in_multiplicand = pa[idx];
            in_multiplier   = pb[idx];
            rdy             = in_ready;
            @(posedge clk);
            if (in_valid && rdy) acc++;
            @(negedge clk);
        end
        checks++; if (acc !== 5) $display("FAIL b2b_accepted got %0d want 5", acc); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready got %b want 0", in_ready); else passed++;
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 6; c++) begin
            in_valid        = (acc < 6);
            in_multiplicand = pa[5];
            in_multiplier   = pb[5];
            rdy             = in_ready;
            if (res_valid) begin
                checks++; if (res_product !== exp_p[got] || res_error !== 1'b0)
                    $display("FAIL b2b_result[%0d] got %0d/%b want %0d/0", got, res_product, res_error, exp_p[got]);
                else passed++;
                got++;
            end
            @(posedge clk);
            if (in_valid && rdy) acc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        checks++; if (got !== 6 || acc !== 6) $display("FAIL b2b_drain got %0d results %0d pushes want 6 6", got, acc); else passed++;
    endtask

    task automatic test_timeout();
        int s_at, s_cnt, v_at;
        bit stable;
        model_en = 1'b0;
        run_one(16'd7, 16'd9, 80, s_at, s_cnt, v_at, stable);
        checks++; if (s_at !== 2) $display("FAIL to_start_cycle got %0d want 2", s_at); else passed++;
        checks++; if (v_at !== 43) $display("FAIL to_valid_cycle got %0d want 43", v_at); else passed++;
        checks++; if (res_product !== 32'd0 || res_error !== 1'b1)
            $display("FAIL to_result got %0d/%b want 0/1", res_product, res_error); else passed++;
        checks++; if (err_timeout !== 1'b1) $display("FAIL to_err_timeout got %b want 1", err_timeout); else passed++;
        release_result();
        model_en    = 1'b1;
        model_delay = 3;
        run_one(16'd2, 16'd3, 30, s_at, s_cnt, v_at, stable);
        checks++; if (v_at !== 6 || res_product !== 32'd6 || res_error !== 1'b0)
            $display("FAIL to_next got cycle %0d %0d/%b want 6 6/0", v_at, res_product, res_error); else passed++;
        checks++; if (err_timeout !== 1'b1) $display("FAIL to_sticky got %b want 1", err_timeout); else passed++;
        release_result();
    endtask

    task automatic test_spurious_and_reset();
        int s_at, s_cnt, v_at, bad;
        bit stable;
        spur_product = 32'd999;
        spur_done    = 1'b1;
        @(negedge clk);
        spur_done    = 1'b0;
        checks++; if (res_valid !== 1'b0 || mul_start !== 1'b0)
            $display("FAIL spur_idle got valid %b start %b want 0 0", res_valid, mul_start); else passed++;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) $display("FAIL spur_idle_late got %b want 0", res_valid); else passed++;
        model_en    = 1'b1;
        model_delay = 3;
        run_one(16'd4, 16'd5, 30, s_at, s_cnt, v_at, stable);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_product !== 32'd20 || res_error !== 1'b0)
            $display("FAIL spur_hold got %b/%0d/%b want 1/20/0", res_valid, res_product, res_error); else passed++;
        release_result();
        model_en = 1'b0;
        push_pair(16'd11, 16'd13);
        push_pair(16'd2, 16'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || mul_start !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_ctrl got valid %b start %b ready %b want 0 0 1", res_valid, mul_start, in_ready); else passed++;
        checks++; if (mul_multiplicand !== 16'd0 || mul_multiplier !== 16'd0)
            $display("FAIL rst_operands got %0d,%0d want 0,0", mul_multiplicand, mul_multiplier); else passed++;
        checks++; if (err_timeout !== 1'b0 || res_product !== 32'd0 || res_error !== 1'b0)
            $display("FAIL rst_result got err %b %0d/%b want 0 0/0", err_timeout, res_product, res_error); else passed++;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mul_start || res_valid) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL rst_queue_empty got %0d active cycles want 0", bad); else passed++;
    endtask

    initial begin
        checks          = 0;
        passed          = 0;
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        res_ready       = 1'b0;
        spur_done       = 1'b0;
        spur_product    = '0;
        model_en        = 1'b0;
        model_delay     = 1;
        test_reset();
        test_multiply();
        test_zero_bypass();
        test_done_at_timeout();
        test_back_to_back();
        test_timeout();
        test_spurious_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mul_issue_unit.md
MUL_ISSUE_UNIT -- requirements
Module: mul_issue_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand width; product width is 2*WIDTH.
REQ-002 Parameter DEPTH, default 4: operand queue entries, power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 40: maximum WAIT cycles before abort.
REQ-004 The block SHALL have a single clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_valid  in  1  operand pair offered.
REQ-008 in_ready  out  1  queue can accept a pair.
REQ-009 in_multiplicand  in  WIDTH  operand A.
REQ-010 in_multiplier  in  WIDTH  operand B.
REQ-011 mul_start  out  1  one-cycle start pulse to the sequential multiplier.
REQ-012 mul_multiplicand  out  WIDTH  operand A held stable from start until done.
REQ-013 mul_multiplier  out  WIDTH  operand B held stable from start until done.
REQ-014 mul_done  in  1  multiplier completion strobe.
REQ-015 mul_product  in  2*WIDTH  multiplier result, valid with mul_done.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  consumer accepts result.
REQ-018 res_product  out  2*WIDTH  result value.
REQ-019 res_error  out  1  result aborted by timeout (res_product = 0).
REQ-020 err_timeout  out  1  sticky timeout flag.

Function
REQ-021 Queue: FIFO of DEPTH {A,B} entries; push on in_valid && in_ready; in_ready = !full; no same-cycle bypass when full.
REQ-022 FSM states: IDLE, ISSUE, WAIT, HOLD; only one operation is in flight; results leave strictly in push order.
REQ-023 IDLE: if queue not empty, pop head into operand registers and go to ISSUE; else stay.
REQ-024 ISSUE: if A == 0 or B == 0, load res_product = 0, res_error = 0 and go to HOLD without pulsing mul_start (zero bypass).
REQ-025 ISSUE: otherwise, assert mul_start for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-026 WAIT: on mul_done, capture mul_product into res_product, res_error = 0, go to HOLD.
REQ-027 WAIT: the counter increments each cycle without mul_done; on reaching TIMEOUT, set err_timeout, res_product = 0, res_error = 1, go to HOLD.
REQ-028 mul_done outside WAIT SHALL be ignored.
REQ-029 mul_done in the same cycle the counter reaches TIMEOUT: done wins, no error.
REQ-030 HOLD: res_valid = 1; res_product and res_error are stable until res_ready; on res_ready go to IDLE with res_valid = 0 next cycle.
REQ-031 Latency, zero bypass: pair pushed at cycle t gives res_valid at t+3 on an empty, idle unit.
REQ-032 Latency, multiply: mul_start at t+2; res_valid one cycle after mul_done.
REQ-033 Pushes SHALL proceed in all states while the queue is not full.
REQ-034 mul_multiplicand and mul_multiplier are driven from the operand registers continuously.

Reset
REQ-035 On rst, and when rst is asserted mid-operation: state = IDLE, queue empty (in_ready = 1 after reset), mul_start = 0, res_valid = 0, res_product = 0, res_error = 0, err_timeout = 0, counter = 0, operand registers = 0.
REQ-036 err_timeout SHALL be cleared only by rst.

Structure
REQ-037 A shared package mul_pkg SHALL hold the FSM state typedef, the default WIDTH, DEPTH and TIMEOUT constants, and the operand-pair struct.
REQ-038 The queue SHALL be a sub-module named mul_operand_fifo (synchronous FIFO with full and empty flags); the FSM lives in mul_issue_unit.

Verification
REQ-039 Push (3, 5) with a model multiplier giving done 17 cycles after start -> one mul_start pulse, operands stable, res_product = 15, res_error = 0.
REQ-040 Push (0, 1234) -> no mul_start, res_valid at t+3, res_product = 0.
REQ-041 Push 6 pairs back-to-back with res_ready = 0 -> in_ready drops after 4 accepted plus 1 in the operand registers; results drain in order once res_ready = 1.
REQ-042 Multiplier never asserts done -> res_valid after TIMEOUT WAIT cycles with res_error = 1, res_product = 0, err_timeout stays 1 across the next operation.
REQ-043 Spurious mul_done in IDLE or HOLD -> no state change; rst asserted during WAIT -> all outputs at reset values and the queue empty.
